trail_writer: RTL and testbench



---
 rtl/tron_pkg.sv | 30 +++
 rtl/trail_writer_if.sv | 12 +
 rtl/fb_addr_gen.sv | 24 ++
 rtl/trail_writer.sv | 197 +++++++++++++++++++
 tb/tb_trail_writer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tron_pkg.sv
// Shared frame-buffer constants, colour codes, FSM state type and word packing
// used by the trail writer and the readout stage.
package tron_pkg;

    localparam logic [3:0] COL_BG   = 4'h8;
    localparam logic [3:0] COL_BLUE = 4'h6;
    localparam logic [3:0] COL_RED  = 4'h4;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int FB_ROW_WORDS = 320;
    localparam int FB_WORDS     = H_RES / 2 * V_RES;

    localparam int ADDR_W = 19;
    localparam int WORD_W = 16;
    localparam int POS_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BLUE,
        ST_RED
    } state_e;

    // Two pixels per word: even pixel in the low nibble, odd pixel in [11:8].
    function automatic logic [WORD_W-1:0] pack_word(input logic [3:0] c);
        return {4'h0, c, 4'h0, c};
    endfunction

endpackage

// File: rtl/trail_writer_if.sv
// Frame-buffer write port: the trail writer drives it, the frameRAM consumes it.
interface trail_writer_if;
    import tron_pkg::*;

    logic              WE;
    logic [ADDR_W-1:0] write_address;
    logic [WORD_W-1:0] Data_In;

    modport master (output WE, write_address, Data_In);
    modport slave  (input  WE, write_address, Data_In);

endinterface

// File: rtl/fb_addr_gen.sv
// Combinational pixel (x, y) to packed word address, with a visibility flag.
// y is 11 bits so that callers adding a row offset never wrap back into range.
module fb_addr_gen #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic [9:0]  x_i,
    input  logic [10:0] y_i,
    output logic [18:0] addr_o,
    output logic        in_range_o
);
    import tron_pkg::*;

    logic [ADDR_W-1:0] x_w;
    logic [ADDR_W-1:0] y_w;

    assign x_w = {{(ADDR_W-10){1'b0}}, x_i};
    assign y_w = {{(ADDR_W-11){1'b0}}, y_i};

    // y*320 as (y<<8)+(y<<6); two pixels per word so x contributes x/2.
    assign addr_o     = (x_w >> 1) + (y_w << 8) + (y_w << 6);
    assign in_range_o = (x_i < 10'(H_RES)) && (y_i < 11'(V_RES));

endmodule

// File: rtl/trail_writer.sv
// Frame-buffer producer: clears the buffer to background, then stamps blue and red
// trail segments on every frame tick. Optional macro: DEAD_BIKE_SKIP_EN.
module trail_writer #(
    parameter int TRAIL_H = 2,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start_clear,
    input  logic [9:0] Blue_X_real,
    input  logic [9:0] Blue_Y_real,
    input  logic [9:0] Red_X_real,
    input  logic [9:0] Red_Y_real,
`ifdef DEAD_BIKE_SKIP_EN
    input  logic       blue_alive,
    input  logic       red_alive,
`endif
    trail_writer_if.master fb,
    output logic       busy,
    output logic       clear_done,
    output logic       overrun
);
    import tron_pkg::*;

    localparam int                CLR_WORDS = (H_RES / 2) * V_RES;
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(CLR_WORDS - 1);
    localparam logic [3:0]        ROW_LAST  = 4'(TRAIL_H - 1);

    state_e            state_q, state_d;
    logic              fs1_q, fs2_q, frame_edge;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [3:0]        row_q, row_d;
    logic [9:0]        bx_q, bx_d, by_q, by_d, rx_q, rx_d, ry_q, ry_d;
`ifdef DEAD_BIKE_SKIP_EN
    logic              red_alive_q, red_alive_d;
`endif
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              clr_done_q, clr_done_d;
    logic              clr_pend_q, clr_pend_d;
    logic              overrun_q, overrun_d;

    logic [9:0]        cur_x, cur_y;
    logic [10:0]       row_y;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_in_range;

    assign frame_edge = fs1_q & ~fs2_q;

    assign cur_x = (state_q == ST_RED) ? rx_q : bx_q;
    assign cur_y = (state_q == ST_RED) ? ry_q : by_q;
    assign row_y = {1'b0, cur_y} + {7'd0, row_q};

    fb_addr_gen #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_addr (
        .x_i        (cur_x),
        .y_i        (row_y),
        .addr_o     (gen_addr),
        .in_range_o (gen_in_range)
    );

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        row_d       = row_q;
        bx_d        = bx_q;
        by_d        = by_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
`ifdef DEAD_BIKE_SKIP_EN
        red_alive_d = red_alive_q;
`endif
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        busy_d      = (state_q != ST_IDLE);
        clr_pend_d  = 1'b0;
        clr_done_d  = clr_pend_q;
        overrun_d   = overrun_q | (frame_edge & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                // A new round wins over a coincident frame tick; that tick is lost.
                if (start_clear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (frame_edge) begin
                    bx_d  = Blue_X_real;
                    by_d  = Blue_Y_real;
                    rx_d  = Red_X_real;
                    ry_d  = Red_Y_real;
                    row_d = '0;
`ifdef DEAD_BIKE_SKIP_EN
                    red_alive_d = red_alive;
                    if (blue_alive)     state_d = ST_BLUE;
                    else if (red_alive) state_d = ST_RED;
                    else                state_d = ST_IDLE;
`else
                    state_d = ST_BLUE;
`endif
                end
            end
            ST_CLEAR: begin
                we_d   = 1'b1;
                addr_d = clr_cnt_q;
                data_d = pack_word(COL_BG);
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d  = '0;
                    clr_pend_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_BLUE: begin
                // Off-screen rows still take their slot so stamp length is fixed.
                we_d   = gen_in_range;
                addr_d = gen_addr;
                data_d = pack_word(COL_BLUE);
                if (row_q == ROW_LAST) begin
                    row_d = '0;
`ifdef DEAD_BIKE_SKIP_EN
                    state_d = red_alive_q ? ST_RED : ST_IDLE;
`else
                    state_d = ST_RED;
`endif
                end else begin
                    row_d = row_q + 4'd1;
                end
            end
            ST_RED: begin
                we_d   = gen_in_range;
                addr_d = gen_addr;
                data_d = pack_word(COL_RED);
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    row_d = row_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        fs1_q <= frame_clk;
        fs2_q <= fs1_q;
        bx_q  <= bx_d;
        by_q  <= by_d;
        rx_q  <= rx_d;
        ry_q  <= ry_d;
        if (Reset) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            row_q       <= '0;
`ifdef DEAD_BIKE_SKIP_EN
            red_alive_q <= 1'b1;
`endif
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            clr_done_q  <= 1'b0;
            clr_pend_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            row_q       <= row_d;
`ifdef DEAD_BIKE_SKIP_EN
            red_alive_q <= red_alive_d;
`endif
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            clr_done_q  <= clr_done_d;
            clr_pend_q  <= clr_pend_d;
            overrun_q   <= overrun_d;
        end
    end

    assign fb.WE            = we_q;
    assign fb.write_address = addr_q;
    assign fb.Data_In       = data_q;
    assign busy             = busy_q;
    assign clear_done       = clr_done_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_trail_writer.sv
// Scoreboard bench for trail_writer: expected writes are queued from a pixel-level
// model of the buffer sweep and trail stamps; a monitor pops them on every WE.
module tb_trail_writer;

    localparam int TRAIL_H  = 2;
    localparam int H_RES    = 640;
    localparam int V_RES    = 16;
    localparam int FB_WORDS = H_RES / 2 * V_RES;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk, start_clear;
    logic [9:0] Blue_X_real, Blue_Y_real, Red_X_real, Red_Y_real;
`ifdef DEAD_BIKE_SKIP_EN
    logic       blue_alive, red_alive;
`endif
    logic       busy, clear_done, overrun;

    trail_writer_if fb();

    trail_writer #(
        .TRAIL_H (TRAIL_H),
        .H_RES   (H_RES),
        .V_RES   (V_RES)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .start_clear (start_clear),
        .Blue_X_real (Blue_X_real),
        .Blue_Y_real (Blue_Y_real),
        .Red_X_real  (Red_X_real),
        .Red_Y_real  (Red_Y_real),
`ifdef DEAD_BIKE_SKIP_EN
        .blue_alive  (blue_alive),
        .red_alive   (red_alive),
`endif
        .fb          (fb),
        .busy        (busy),
        .clear_done  (clear_done),
        .overrun     (overrun)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int exp_a[$];
    int exp_d[$];
    int mon_a, mon_d;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT presents must match the head of the queue.
    always @(negedge Clk) begin
        if (fb.WE === 1'b1) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0d data=%h expected=no write",
                         fb.write_address, fb.Data_In);
            end else begin
                mon_a = exp_a.pop_front();
                mon_d = exp_d.pop_front();
                chk("wr_addr", fb.write_address, mon_a);
                chk("wr_data", fb.Data_In, mon_d);
            end
        end
        if (clear_done === 1'b1) begin
            done_pulses++;
            chk("busy_low_at_clear_done", busy, 0);
        end
    end

    task automatic tick;
        @(negedge Clk);
        #1;
    endtask

    function automatic int word_of(input int colour);
        return colour * 257;
    endfunction

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(word_of(8));
        end
    endtask

    // Reference: each visible row of the trail is one word at x/2 + y*320.
    task automatic push_stamp(input int x, input int y, input int colour);
        for (int r = 0; r < TRAIL_H; r++) begin
            if (x < H_RES && (y + r) < V_RES) begin
                exp_a.push_back(x / 2 + (y + r) * 320);
                exp_d.push_back(word_of(colour));
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick;
            n++;
        end while (clear_done !== 1'b1 && n < FB_WORDS + 50);
    endtask

    task automatic do_frame(input int bx, input int by, input int rx, input int ry,
                            input bit ba, input bit ra);
        int n, exp_cyc, first;
        exp_cyc = 0;
`ifndef DEAD_BIKE_SKIP_EN
        ba = 1'b1;
        ra = 1'b1;
`endif
        if (ba) begin push_stamp(bx, by, 6); exp_cyc += TRAIL_H; end
        if (ra) begin push_stamp(rx, ry, 4); exp_cyc += TRAIL_H; end
        Blue_X_real = 10'(bx);
        Blue_Y_real = 10'(by);
        Red_X_real  = 10'(rx);
        Red_Y_real  = 10'(ry);
`ifdef DEAD_BIKE_SKIP_EN
        blue_alive = ba;
        red_alive  = ra;
`endif
        frame_clk = 1'b1;
        tick;
        tick;
        // Positions are latched by now; later changes must not leak into the stamp.
        Blue_X_real = 10'($urandom_range(0, 1023));
        Blue_Y_real = 10'($urandom_range(0, 1023));
        Red_X_real  = 10'($urandom_range(0, 1023));
        Red_Y_real  = 10'($urandom_range(0, 1023));
`ifdef DEAD_BIKE_SKIP_EN
        blue_alive = ~ba;
        red_alive  = ~ra;
`endif
        frame_clk = 1'b0;
        n = 0;
        first = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (i == 0) first = busy;
            if (busy) n++;
        end
        chk("stamp_latency", first, (exp_cyc > 0) ? 1 : 0);
        chk("stamp_cycles", n, exp_cyc);
        chk("stamp_drained", exp_a.size(), 0);
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        frame_clk = 1'b0;
        start_clear = 1'b0;
        Blue_X_real = '0;
        Blue_Y_real = '0;
        Red_X_real  = '0;
        Red_Y_real  = '0;
`ifdef DEAD_BIKE_SKIP_EN
        blue_alive = 1'b1;
        red_alive  = 1'b1;
`endif
        repeat (3) tick;
        chk("rst_we", fb.WE, 0);
        chk("rst_addr", fb.write_address, 0);
        chk("rst_data", fb.Data_In, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_overrun", overrun, 0);

        // Power-up sweep
        push_clear(FB_WORDS);
        Reset = 1'b0;
        wait_done(n);
        chk("init_clear_cycles", n, FB_WORDS + 1);
        chk("init_clear_drained", exp_a.size(), 0);
        chk("overrun_after_clear", overrun, 0);

        // Directed stamps: nominal, bottom row, far edges, Y near 1023
        do_frame(100, 5, 301, 10, 1, 1);
        do_frame(100, 5, 301, V_RES - 1, 1, 1);
        do_frame(639, 1023, 640, 0, 1, 1);
        do_frame(0, 0, 1, V_RES - 2, 1, 1);
        do_frame(1023, 1022, 638, 1023, 1, 1);
`ifdef DEAD_BIKE_SKIP_EN
        do_frame(100, 5, 301, 10, 0, 1);
        do_frame(100, 5, 301, 10, 1, 0);
        do_frame(100, 5, 301, 10, 0, 0);
`endif
        for (int i = 0; i < 24; i++) begin
            do_frame($urandom_range(0, 700), $urandom_range(0, V_RES + 2),
                     $urandom_range(0, 700), $urandom_range(0, V_RES + 2),
                     1'($urandom_range(0, 1)) | 1'(i < 12), 1'($urandom_range(0, 1)) | 1'(i < 12));
        end
        chk("overrun_idle_frames", overrun, 0);

        // start_clear and frame edge land in the same IDLE cycle
        push_clear(FB_WORDS);
        frame_clk = 1'b1;
        tick;
        start_clear = 1'b1;
        tick;
        start_clear = 1'b0;
        frame_clk = 1'b0;
        wait_done(n);
        chk("coincident_clear_cycles", n, FB_WORDS + 1);
        chk("coincident_no_overrun", overrun, 0);
        chk("coincident_drained", exp_a.size(), 0);

        // Frame edge during CLEAR
        push_clear(FB_WORDS);
        start_clear = 1'b1;
        tick;
        start_clear = 1'b0;
        repeat (10) tick;
        frame_clk = 1'b1;
        repeat (3) tick;
        frame_clk = 1'b0;
        wait_done(n);
        chk("overrun_clear_cycles", n, FB_WORDS + 1 - 13);
        chk("overrun_set", overrun, 1);
        do_frame(200, 3, 50, 7, 1, 1);
        chk("overrun_sticky", overrun, 1);

        // Reset while CLEAR is at address 1000
        push_clear(1001);
        start_clear = 1'b1;
        tick;
        start_clear = 1'b0;
        n = 0;
        while (exp_a.size() != 0 && n < 2000) begin
            tick;
            n++;
        end
        chk("abort_point_cycles", n, 1001);
        Reset = 1'b1;
        tick;
        chk("abort_we", fb.WE, 0);
        chk("abort_addr", fb.write_address, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        push_clear(FB_WORDS);
        Reset = 1'b0;
        wait_done(n);
        chk("restart_clear_cycles", n, FB_WORDS + 1);
        chk("restart_drained", exp_a.size(), 0);
        do_frame(320, 8, 321, 9, 1, 1);
        chk("overrun_after_reset", overrun, 0);
        chk("clear_done_pulses", done_pulses, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
